// File: rtl/blk_compare.sv
// blk_compare: compares one 16x16 current macroblock against the co-located
//   previous-frame candidate, writing signed residuals and accumulating SAD.
// Latency: pixel k issued in cycle k+1, consumed in k+2, written/accumulated
//   in k+3; with no stalls valid pulses in cycle 258 and rdy returns in 259.
// Backpressure: mwait=1 freezes issue and consume for that cycle (one extra
//   cycle per stall, no write); early abort once the running SAD cannot win.
//
// Ports:
//   clk, reset_n        clock; synchronous reset, active-high despite the name
//   en / rdy            start request (sampled only while rdy=1) / idle flag
//   baddr, bq           current-block RAM address and data (bq[7:0] used)
//   mx, my, mq          previous-frame column/row offset and returned pixel
//   mwait               previous-frame memory stall
//   waddr, wdata, wren  residual RAM write port (9-bit residual sign-extended)
//   oldaccum, accum     best SAD so far (latched at start) / this candidate's SAD
//   valid               one-cycle pulse: full block compared and accum < best

module blk_compare (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic        rdy,
  output logic [7:0]  baddr,
  input  logic [15:0] bq,
  output logic [3:0]  mx,
  output logic [3:0]  my,
  input  logic [7:0]  mq,
  input  logic        mwait,
  output logic [7:0]  waddr,
  output logic [15:0] wdata,
  output logic        wren,
  input  logic [17:0] oldaccum,
  output logic [17:0] accum,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [17:0] best_r;    // SAD to beat, frozen for the whole run
  logic [7:0]  pix;       // index of the pixel whose data is on bq/mq
  logic        pend;      // an address has been issued, so bq/mq carry real data

  logic [8:0]  diff;
  logic [8:0]  mag;
  logic [17:0] acc_nxt;
  logic        unused_bq_hi;

  // Upper byte of the current-block word carries no luma.
  assign unused_bq_hi = ^bq[15:8];

  // Previous-frame coordinates are just the pixel index split into col/row.
  assign mx = baddr[3:0];
  assign my = baddr[7:4];

  always_comb begin
    diff    = {1'b0, bq[7:0]} - {1'b0, mq};
    mag     = diff[8] ? (9'd0 - diff) : diff;
    acc_nxt = accum + {9'd0, mag};
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      baddr  <= 8'd0;
      waddr  <= 8'd0;
      wdata  <= 16'd0;
      wren   <= 1'b0;
      accum  <= 18'd0;
      valid  <= 1'b0;
      best_r <= 18'd0;
      pix    <= 8'd0;
      pend   <= 1'b0;
    end else begin
      // Strobes are single-cycle; only a consume cycle re-raises wren/valid.
      wren  <= 1'b0;
      valid <= 1'b0;

      case (state)
        IDLE: begin
          if (en) begin
            best_r <= oldaccum;
            accum  <= 18'd0;
            baddr  <= 8'd0;
            pix    <= 8'd0;
            pend   <= 1'b0;
            rdy    <= 1'b0;
            state  <= RUN;
          end
        end

        RUN: begin
          // A stall freezes address, index and accumulator together so the
          // stalled memory re-presents the same data next cycle.
          if (!mwait) begin
            // Address stops at the last pixel; re-reading it is harmless.
            if (baddr != 8'hFF) begin
              baddr <= baddr + 8'd1;
            end
            pend <= 1'b1;

            if (pend) begin
              wren  <= 1'b1;
              waddr <= pix;
              wdata <= {{7{diff[8]}}, diff};
              accum <= acc_nxt;

              if (pix == 8'hFF) begin
                valid <= (acc_nxt < best_r);
                state <= DRAIN;
              end else if (acc_nxt >= best_r) begin
                // Running SAD already ties or exceeds the best: cannot win.
                state <= DRAIN;
              end else begin
                pix <= pix + 8'd1;
              end
            end
          end
        end

        DRAIN: begin
          // Final residual write and valid are presented in this cycle.
          rdy   <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blk_compare.sv
// Directed bench for blk_compare. Expected residual writes are pushed to a
// scoreboard queue when a run is launched and popped as wren pulses appear;
// run-level results are checked against fixed expected values.

module tb_blk_compare;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        rdy;
  logic [7:0]  baddr;
  logic [15:0] bq;
  logic [3:0]  mx;
  logic [3:0]  my;
  logic [7:0]  mq;
  logic        mwait;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        wren;
  logic [17:0] oldaccum;
  logic [17:0] accum;
  logic        valid;

  always #5 clk = ~clk;

  blk_compare dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .rdy      (rdy),
    .baddr    (baddr),
    .bq       (bq),
    .mx       (mx),
    .my       (my),
    .mq       (mq),
    .mwait    (mwait),
    .waddr    (waddr),
    .wdata    (wdata),
    .wren     (wren),
    .oldaccum (oldaccum),
    .accum    (accum),
    .valid    (valid)
  );

  // Memories: registered read, output frozen while mwait is high so the
  // stalled data is re-presented on the next cycle.
  logic [15:0] bmem [256];
  logic [7:0]  pmem [256];

  always @(posedge clk) begin
    if (!mwait) begin
      bq <= bmem[baddr];
      mq <= pmem[{my, mx}];
    end
  end

  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          wr_cnt  = 0;
  int          vld_cnt = 0;
  int          vld_cyc = -1;
  int          stalls  = 0;
  logic [23:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample outputs 1 time unit after the edge.
  task automatic tick();
    logic [23:0] e;
    if (vld_cnt == 0 && cyc >= 1 && mwait) stalls++;
    @(posedge clk);
    #1;
    cyc++;
    if (wren === 1'b1) begin
      wr_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write cycle=%0d waddr=%0d wdata=%04h expected no write",
               cyc, waddr, wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write", {8'h00, waddr, wdata}, {8'h00, e});
      end
    end
    if (valid === 1'b1) begin
      vld_cnt++;
      vld_cyc = cyc;
    end
  endtask

  // Reference: walk pixels in order, stop once the SAD reaches the best.
  task automatic build_expect(input logic [17:0] old);
    int          d;
    logic [17:0] acc;
    acc = 18'd0;
    for (int i = 0; i < 256; i++) begin
      d   = int'(bmem[i][7:0]) - int'(pmem[i]);
      acc = acc + 18'((d < 0) ? -d : d);
      exp_q.push_back({8'(i), 16'(d)});
      if (acc >= old) break;
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       begin bmem[i] = {8'($urandom), 8'(i)};   pmem[i] = 8'(i);   end
        1:       begin bmem[i] = {8'($urandom), 8'd100};  pmem[i] = 8'd90;   end
        default: begin bmem[i] = {8'($urandom), 8'd0};    pmem[i] = 8'd255;  end
      endcase
    end
  endtask

  // exp_rdy < 0 means "259 plus the observed stall count".
  task automatic run_block(input string tag, input logic [17:0] old, input bit stl,
                           input logic [17:0] exp_acc, input bit exp_vld,
                           input int exp_wr, input int exp_rdy);
    build_expect(old);
    wr_cnt = 0; vld_cnt = 0; vld_cyc = -1; stalls = 0; cyc = 0;
    oldaccum = old;
    en       = 1'b1;
    mwait    = 1'b0;
    tick();
    en       = 1'b0;
    oldaccum = 18'($urandom);   // only the latched copy may matter now
    chk({tag, "_busy"},   32'(rdy),   32'd0);
    chk({tag, "_baddr0"}, 32'(baddr), 32'd0);
    while (rdy !== 1'b1 && cyc < 1000) begin
      mwait = stl && (cyc % 3 == 0);
      tick();
    end
    mwait = 1'b0;
    chk({tag, "_done_in_budget"}, 32'(rdy), 32'd1);
    chk({tag, "_accum"},     32'(accum),        32'(exp_acc));
    chk({tag, "_valid_cnt"}, 32'(vld_cnt),      exp_vld ? 32'd1 : 32'd0);
    chk({tag, "_writes"},    32'(wr_cnt),       32'(exp_wr));
    chk({tag, "_q_empty"},   32'(exp_q.size()), 32'd0);
    if (exp_vld) chk({tag, "_valid_cyc"}, 32'(vld_cyc), 32'(258 + stalls));
    chk({tag, "_rdy_cyc"}, 32'(cyc), (exp_rdy < 0) ? 32'(259 + stalls) : 32'(exp_rdy));
    tick();
    chk({tag, "_accum_hold"}, 32'(accum), 32'(exp_acc));
    exp_q.delete();
  endtask

  initial begin
    reset_n  = 1'b1;
    en       = 1'b0;
    mwait    = 1'b0;
    oldaccum = 18'd0;
    fill(0);
    repeat (3) tick();
    chk("rst_rdy",   32'(rdy),   32'd1);
    chk("rst_baddr", 32'(baddr), 32'd0);
    chk("rst_mxmy",  32'({my, mx}), 32'd0);
    chk("rst_wren",  32'(wren),  32'd0);
    chk("rst_wdata", 32'({waddr, wdata}), 32'd0);
    chk("rst_accum", 32'(accum), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    reset_n = 1'b0;
    tick();

    fill(0); run_block("ident",    18'd100,     1'b0, 18'd0,     1'b1, 256, 259);
    fill(1); run_block("diff10",   18'd3000,    1'b0, 18'd2560,  1'b1, 256, 259);
    fill(1); run_block("tie",      18'd2560,    1'b0, 18'd2560,  1'b0, 256, 259);
    fill(2); run_block("maxdiff",  18'h3FFFF,   1'b0, 18'd65280, 1'b1, 256, 259);
    fill(1); run_block("abort5",   18'd50,      1'b0, 18'd50,    1'b0, 5,   8);
    fill(0); run_block("stall",    18'd100,     1'b1, 18'd0,     1'b1, 256, -1);

    // en held high with oldaccum=0: each run aborts after one pixel and the
    // next run starts on the first rdy=1 cycle.
    fill(1);
    build_expect(18'd0);
    build_expect(18'd0);
    wr_cnt = 0; vld_cnt = 0; cyc = 0;
    oldaccum = 18'd0;
    en = 1'b1;
    repeat (4) tick();
    chk("enhold_rdy_c4", 32'(rdy), 32'd1);
    tick();
    chk("enhold_rdy_c5", 32'(rdy), 32'd0);
    en = 1'b0;
    while (rdy !== 1'b1 && cyc < 50) tick();
    chk("enhold_rdy_cyc", 32'(cyc),          32'd8);
    chk("enhold_writes",  32'(wr_cnt),       32'd2);
    chk("enhold_accum",   32'(accum),        32'd10);
    chk("enhold_valid",   32'(vld_cnt),      32'd0);
    chk("enhold_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset in the middle of a run.
    fill(0);
    build_expect(18'd100);
    wr_cnt = 0; vld_cnt = 0; cyc = 0;
    oldaccum = 18'd100;
    en = 1'b1;
    tick();
    en = 1'b0;
    while (cyc < 100) tick();
    chk("midrst_writes_before", 32'(wr_cnt), 32'd98);
    reset_n = 1'b1;
    tick();
    chk("midrst_rdy",   32'(rdy),   32'd1);
    chk("midrst_wren",  32'(wren),  32'd0);
    chk("midrst_accum", 32'(accum), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_baddr", 32'(baddr), 32'd0);
    reset_n = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    repeat (6) tick();
    chk("midrst_no_writes", 32'(wr_cnt), 32'd0);
    chk("midrst_idle_rdy",  32'(rdy),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
